fismos_axi_ctrl_regs: RTL and testbench

FISMOS_AXI_CTRL_REGS -- requirements
Module: fismos_axi_ctrl_regs

---
 rtl/fismos_axi_ctrl_regs.sv | 176 +++++++++++++++++
 tb/tb_fismos_axi_ctrl_regs.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fismos_axi_ctrl_regs.sv
// AXI4-Lite slave with four 32-bit registers: CONTROL (RW, bit 0 reads 0 and fires ctrl_start),
// STATUS (RO), SCRATCH (RW) and DOUT (RO). Independent write and read channel FSMs.
module fismos_axi_ctrl_regs #(
    parameter int C_AXI_ADDR_WIDTH = 4,
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    output logic [1:0]                    S_AXI_BRESP,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic [31:0]                   ctrl_reg,
    output logic                          ctrl_start,
    input  logic [31:0]                   status_in,
    input  logic [31:0]                   dout_in
);

    localparam logic [1:0] IDX_CTRL    = 2'd0;
    localparam logic [1:0] IDX_STATUS  = 2'd1;
    localparam logic [1:0] IDX_SCRATCH = 2'd2;
    localparam logic [1:0] IDX_DOUT    = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_VALID} rstate_t;

    wstate_t     wstate;
    rstate_t     rstate;
    logic [1:0]  aw_idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] scratch_q;

    logic        aw_hs, w_hs, ar_hs, commit_go;
    logic [1:0]  c_idx;
    logic [31:0] c_data;
    logic [3:0]  c_strb;

    // Protection bits and the byte offset within a word play no part in decode.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    assign S_AXI_RRESP = 2'b00;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = s[i] ? d[i*8 +: 8] : old[i*8 +: 8];
        return r;
    endfunction

    always_comb begin
        aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs      = S_AXI_WVALID && S_AXI_WREADY;
        ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
        commit_go = ((wstate == W_IDLE) && aw_hs && w_hs) ||
                    ((wstate == W_ADDR) && w_hs) ||
                    ((wstate == W_DATA) && aw_hs);
        // Whichever half was captured earlier comes from the holding register.
        c_idx  = (wstate == W_ADDR) ? aw_idx_q : S_AXI_AWADDR[3:2];
        c_data = (wstate == W_DATA) ? wdata_q  : S_AXI_WDATA;
        c_strb = (wstate == W_DATA) ? wstrb_q  : S_AXI_WSTRB;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wstate        <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            aw_idx_q      <= 2'd0;
            wdata_q       <= 32'd0;
            wstrb_q       <= 4'd0;
            ctrl_reg      <= 32'd0;
            scratch_q     <= 32'd0;
            ctrl_start    <= 1'b0;
        end else begin
            ctrl_start <= 1'b0;
            if (commit_go) begin
                case (c_idx)
                    IDX_CTRL: begin
                        ctrl_reg    <= merge(ctrl_reg, c_data, c_strb) & 32'hFFFF_FFFE;
                        ctrl_start  <= c_strb[0] && c_data[0];
                        S_AXI_BRESP <= 2'b00;
                    end
                    IDX_SCRATCH: begin
                        scratch_q   <= merge(scratch_q, c_data, c_strb);
                        S_AXI_BRESP <= 2'b00;
                    end
                    default: S_AXI_BRESP <= 2'b10;
                endcase
                S_AXI_BVALID  <= 1'b1;
                S_AXI_AWREADY <= 1'b0;
                S_AXI_WREADY  <= 1'b0;
                wstate        <= W_RESP;
            end else begin
                case (wstate)
                    W_IDLE: begin
                        // Also raises both readys on the first edge out of reset.
                        S_AXI_AWREADY <= !aw_hs;
                        S_AXI_WREADY  <= !w_hs;
                        if (aw_hs) begin
                            aw_idx_q <= S_AXI_AWADDR[3:2];
                            wstate   <= W_ADDR;
                        end else if (w_hs) begin
                            wdata_q <= S_AXI_WDATA;
                            wstrb_q <= S_AXI_WSTRB;
                            wstate  <= W_DATA;
                        end
                    end
                    W_RESP: begin
                        if (S_AXI_BREADY) begin
                            S_AXI_BVALID  <= 1'b0;
                            S_AXI_AWREADY <= 1'b1;
                            S_AXI_WREADY  <= 1'b1;
                            wstate        <= W_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register values sampled here are pre-commit on a coincident write edge.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rstate        <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (ar_hs) begin
                        case (S_AXI_ARADDR[3:2])
                            IDX_CTRL:    S_AXI_RDATA <= ctrl_reg;
                            IDX_STATUS:  S_AXI_RDATA <= status_in;
                            IDX_SCRATCH: S_AXI_RDATA <= scratch_q;
                            default:     S_AXI_RDATA <= dout_in;
                        endcase
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_ARREADY <= 1'b0;
                        rstate        <= R_VALID;
                    end
                end
                default: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        rstate        <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fismos_axi_ctrl_regs.sv
// Directed bench for fismos_axi_ctrl_regs: handshake ordering, byte strobes, RO errors,
// read/write concurrency and mid-transaction reset.
module tb_fismos_axi_ctrl_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
    logic        arvalid = 0, arready, rvalid, rready = 0;
    logic [3:0]  awaddr = 0, araddr = 0;
    logic [2:0]  awprot = 0, arprot = 0;
    logic [31:0] wdata = 0, rdata, ctrl_reg, status_in = 0, dout_in = 0;
    logic [3:0]  wstrb = 0;
    logic [1:0]  bresp, rresp;
    logic        ctrl_start;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fismos_axi_ctrl_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr),
        .S_AXI_AWPROT(awprot), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata),
        .S_AXI_RRESP(rresp), .ctrl_reg(ctrl_reg), .ctrl_start(ctrl_start),
        .status_in(status_in), .dout_in(dout_in)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // AW and W presented together.
    task automatic wr_same(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_resp);
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        chk("wr_rdy", n < 20, 1);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("wr_bvalid", bvalid, 1);
        chk("wr_bresp", bresp, exp_resp);
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("wr_bclr", bvalid, 0);
        chk("wr_idle_rdy", {awready, wready}, 2'b11);
    endtask

    // One channel first, the other gap cycles later; returns ctrl_start in the
    // cycle right after commit and the one following.
    task automatic wr_split(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic aw_first, input int gap, input logic [1:0] exp_resp,
                            output logic s0, output logic s1);
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        if (aw_first) awvalid = 1; else wvalid = 1;
        while (!(aw_first ? awready : wready) && n < 20) begin @(negedge clk); n++; end
        chk("sp_rdy1", n < 20, 1);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("sp_early_b", bvalid, 0);
        chk("sp_other_rdy", aw_first ? {awready, wready} : {wready, awready}, 2'b01);
        for (int i = 0; i < gap; i++) @(negedge clk);
        chk("sp_still_no_b", bvalid, 0);
        if (aw_first) wvalid = 1; else awvalid = 1;
        n = 0;
        while (!(aw_first ? wready : awready) && n < 20) begin @(negedge clk); n++; end
        chk("sp_rdy2", n < 20, 1);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("sp_bvalid", bvalid, 1);
        chk("sp_bresp", bresp, exp_resp);
        s0 = ctrl_start;
        @(negedge clk);
        chk("sp_bhold", bvalid, 1);
        s1 = ctrl_start;
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("sp_bclr", bvalid, 0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input int hold);
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        chk("rd_rdy", n < 20, 1);
        @(negedge clk);
        arvalid = 0;
        chk("rd_rvalid", rvalid, 1);
        chk("rd_data", rdata, exp);
        chk("rd_rresp", rresp, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rd_hold_data", rdata, exp);
            chk("rd_hold_arrdy", {arready, rvalid}, 2'b01);
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
        chk("rd_rclr", {rvalid, arready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic s0, s1;
        repeat (2) @(negedge clk);
        chk("rst_rdys", {awready, wready, arready}, 3'b000);
        chk("rst_resp", {bvalid, rvalid, ctrl_start}, 3'b000);
        chk("rst_ctrl", ctrl_reg, 0);
        chk("rst_rdata", rdata, 0);
        rst = 0;
        @(negedge clk);
        chk("rel_rdys", {awready, wready, arready}, 3'b111);

        wr_same(4'h8, 32'hDEADBEEF, 4'hF, 2'b00);
        rd(4'h8, 32'hDEADBEEF, 0);

        // W first, AW three cycles later, CONTROL bit 0 set
        wr_split(4'h0, 32'h0000_0005, 4'hF, 1'b0, 2, 2'b00, s0, s1);
        chk("start_pulse", s0, 1);
        chk("start_gone", s1, 0);
        chk("ctrl_val", ctrl_reg, 32'h0000_0004);
        rd(4'h0, 32'h0000_0004, 0);

        wr_same(4'h8, 32'h11223344, 4'h2, 2'b00);
        rd(4'h8, 32'hDEAD33EF, 0);
        wr_same(4'h8, 32'hFFFFFFFF, 4'h0, 2'b00);
        rd(4'h9, 32'hDEAD33EF, 0);

        status_in = 32'hA5A5A5A5;
        dout_in   = 32'h5A5A0FF0;
        wr_same(4'h4, 32'h12345678, 4'hF, 2'b10);
        wr_same(4'hC, 32'h12345678, 4'hF, 2'b10);
        chk("ro_ctrl_kept", ctrl_reg, 32'h0000_0004);
        rd(4'h4, 32'hA5A5A5A5, 4);
        rd(4'hF, 32'h5A5A0FF0, 0);
        rd(4'h8, 32'hDEAD33EF, 0);

        // AW first to CONTROL with bit 0 clear: no pulse
        wr_split(4'h0, 32'h8000_00F2, 4'hF, 1'b1, 1, 2'b00, s0, s1);
        chk("nostart0", s0, 0);
        chk("nostart1", s1, 0);
        chk("ctrl_val2", ctrl_reg, 32'h8000_00F2);
        // AW first to SCRATCH through unaligned address, upper half only
        wr_split(4'hB, 32'hCAFE0000, 4'hC, 1'b1, 3, 2'b00, s0, s1);
        rd(4'h8, 32'hCAFE33EF, 0);

        // Read sampled on the same edge as a commit to the same register
        @(negedge clk);
        awaddr = 4'h8; wdata = 32'h0BADF00D; wstrb = 4'hF; araddr = 4'h8;
        awvalid = 1; wvalid = 1; arvalid = 1;
        chk("conc_rdys", {awready, wready, arready}, 3'b111);
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("conc_b", bvalid, 1);
        chk("conc_r", rvalid, 1);
        chk("conc_old", rdata, 32'hCAFE33EF);
        bready = 1; rready = 1;
        @(negedge clk);
        bready = 0; rready = 0;
        rd(4'h8, 32'h0BADF00D, 0);

        // Reset with B and R both pending
        @(negedge clk);
        awaddr = 4'h0; wdata = 32'h0000_0100; wstrb = 4'hF; araddr = 4'h8;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("pre_rst_b", bvalid, 1);
        chk("pre_rst_ctrl", ctrl_reg, 32'h0000_0100);
        rst = 1;
        #1;
        chk("mid_rst_resp", {bvalid, rvalid}, 2'b00);
        chk("mid_rst_ctrl", ctrl_reg, 0);
        chk("mid_rst_rdys", {awready, wready, arready}, 3'b000);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("post_rst_rdys", {awready, wready, arready}, 3'b111);
        chk("post_rst_resp", {bvalid, rvalid}, 2'b00);
        rd(4'h8, 32'h0, 0);
        wr_same(4'h8, 32'h12345678, 4'hF, 2'b00);
        rd(4'h8, 32'h12345678, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
